// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one async-FIFO write port among NUM_REQ producers
// Optional per-packet burst grants are compiled in with ARB_BURST_EN.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                     wr_clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     wr_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_wr_data,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          grant_id,
    output logic [15:0]              wr_count
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ID_W-1:0]        r_grant_id;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [15:0]            r_wr_count;
    logic [ID_W-1:0]        w_next_grant;
    logic [ID_W-1:0]        w_next_ptr;
    logic                   w_new_grant;
    logic [ID_W-1:0]        w_winner;
    logic                   w_any_valid;
    logic [2*NUM_REQ-1:0]   w_rot;
    logic                   w_found;
    logic                   w_owner_valid;
    logic [WIDTH-1:0]       w_owner_data;
    logic                   w_accept;
    logic                   w_release;

    assign w_any_valid   = |req_valid;
    assign w_owner_valid = req_valid[r_grant_id];
    assign w_owner_data  = WIDTH'(req_data >> (int'(r_grant_id) * WIDTH));
    assign w_accept      = (r_state == S_BUSY) && w_owner_valid && !wr_full && !reset;

    // Rotate the valid vector so bit 0 is the requester at rr_ptr, then take the first set bit.
    assign w_rot = {req_valid, req_valid} >> r_rr_ptr;

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found  = 1'b1;
                w_winner = ID_W'((int'(r_rr_ptr) + j) % NUM_REQ);
            end
        end
    end

`ifdef ARB_BURST_EN
    logic [7:0] r_beat_cnt;

    assign w_release = w_accept && (req_last[r_grant_id] || (r_beat_cnt == 8'(MAX_BURST - 1)));

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_beat_cnt <= '0;
        end else if (w_new_grant) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = ^req_last;
    assign w_release     = (r_state == S_BUSY) && (w_accept || !w_owner_valid);
`endif

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_wr_count <= '0;
        end else begin
            r_state    <= w_next_state;
            r_grant_id <= w_next_grant;
            r_rr_ptr   <= w_next_ptr;
            if (w_accept && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    // rr_ptr always holds the index after the most recent owner, so both IDLE and release searches use it.
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant_id;
        w_next_ptr   = r_rr_ptr;
        w_new_grant  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_valid) begin
                    w_next_state = S_BUSY;
                    w_new_grant  = 1'b1;
                end
            end
            S_BUSY: begin
                if (w_release) begin
                    if (w_any_valid) begin
                        w_new_grant = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (w_new_grant) begin
            w_next_grant = w_winner;
            w_next_ptr   = ID_W'((int'(w_winner) + 1) % NUM_REQ);
        end
    end

    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = w_accept;
        fifo_wr_data = w_accept ? w_owner_data : '0;
        grant_valid  = (r_state == S_BUSY);
        grant_id     = r_grant_id;
        wr_count     = r_wr_count;
        if ((r_state == S_BUSY) && !wr_full && !reset) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and random checks of fifo_wr_arbiter against a behavioural model
module tb_fifo_wr_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int MB  = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           wr_full;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_wr_data;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [15:0]    wr_count;

    int total = 0;
    int bad   = 0;

    int m_owner = -1;
    int m_gid   = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_beats = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .WIDTH(W), .NUM_REQ(N), .ID_W(IDW), .MAX_BURST(MB)
    ) dut (
        .wr_clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .wr_full(wr_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .grant_valid(grant_valid), .grant_id(grant_id), .wr_count(wr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int from);
        for (int k = 0; k < N; k++) begin
            if (v[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    // One clock: drive inputs, compare outputs mid-cycle, then advance the model across the edge.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic f,
                        input logic [N-1:0] l, input logic r);
        logic [N-1:0] e_ready;
        logic         e_acc;
        logic [W-1:0] e_data;
        bit           rel;
        reset = r; req_valid = v; req_data = d; wr_full = f; req_last = l;
        @(negedge clk);
        e_ready = '0; e_acc = 1'b0; e_data = '0;
        if (!r && m_owner >= 0) begin
            e_ready = f ? '0 : N'(1 << m_owner);
            e_acc   = v[m_owner] && !f;
            if (e_acc) e_data = W'(d >> (m_owner * W));
        end
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("fifo_wr_en", 32'(fifo_wr_en), 32'(e_acc));
        check("fifo_wr_data", 32'(fifo_wr_data), 32'(e_data));
        check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        if (m_owner >= 0) check("grant_id", 32'(grant_id), 32'(m_gid));
        check("wr_count", 32'(wr_count), 32'(m_cnt));
        if (r) begin
            m_owner = -1; m_gid = 0; m_ptr = 0; m_cnt = 0; m_beats = 0;
        end else begin
            if (e_acc && m_cnt < 65535) m_cnt++;
            rel = 1'b1;
            if (m_owner >= 0) begin
`ifdef ARB_BURST_EN
                if (e_acc) m_beats++;
                rel = e_acc && (l[m_owner] || m_beats == MB);
`else
                rel = e_acc || !v[m_owner];
`endif
                if (rel) m_ptr = (m_owner + 1) % N;
            end
            if (rel) begin
                m_owner = pick(v, m_ptr);
                if (m_owner >= 0) begin
                    m_gid   = m_owner;
                    m_beats = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N*W-1:0] d;
        int             iter;
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; wr_full = 1'b0;

        // Reset state
        step('0, '0, 1'b0, '0, 1'b1);
        step('0, '0, 1'b0, '0, 1'b1);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);

        // Single requester 0 with data 0A
        d = '0; d[7:0] = 8'h0A;
        step(4'b0001, d, 1'b0, '0, 1'b0);
        step(4'b0001, d, 1'b0, '0, 1'b0);
        check("t1_count", 32'(wr_count), 32'd1);
        step('0, '0, 1'b0, '0, 1'b0);

        // All four valid: grants rotate 0,1,2,3,0
        step('0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(4'b1111, {$urandom, $urandom}, 1'b0, '0, 1'b0);
        end

        // Full holds owner 2 for 5 cycles
        step('0, '0, 1'b0, '0, 1'b1);
        step(4'b0100, 32'h33221100, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0100, 32'h33221100, 1'b1, '0, 1'b0);
        check("full_hold_id", 32'(grant_id), 32'd2);
        step(4'b0100, 32'h33221100, 1'b0, '0, 1'b0);

`ifdef ARB_BURST_EN
        // 3-beat packet from 1 with 3 waiting, then a 10-beat packet split after MAX_BURST
        step('0, '0, 1'b0, '0, 1'b1);
        step(4'b1010, 32'hD0C0B0A0, 1'b0, '0, 1'b0);
        step(4'b1010, 32'hD0C0B0A1, 1'b0, '0, 1'b0);
        step(4'b1010, 32'hD0C0B0A2, 1'b0, '0, 1'b0);
        step(4'b1010, 32'hD0C0B0A3, 1'b0, 4'b0010, 1'b0);
        check("burst_next_id", 32'(grant_id), 32'd3);
        step(4'b1000, 32'hD0C0B0A4, 1'b0, 4'b1000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(4'b0010, {$urandom}, 1'b0, (i == 9) ? 4'b0010 : 4'b0000, 1'b0);
        end
        step('0, '0, 1'b0, '0, 1'b0);
`endif

        // Reset in the middle of a grant
        step('0, '0, 1'b0, '0, 1'b1);
        step(4'b0001, 32'h5A, 1'b0, '0, 1'b0);
        step(4'b0001, 32'h5A, 1'b0, '0, 1'b0);
        step(4'b0001, 32'h5A, 1'b0, '0, 1'b1);
        check("mid_rst_count", 32'(wr_count), 32'd0);
        check("mid_rst_grant", 32'(grant_valid), 32'd0);
        check("mid_rst_id", 32'(grant_id), 32'd0);
        step('0, '0, 1'b0, '0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom), {$urandom}, ($urandom_range(0, 3) == 0),
                 N'($urandom), ($urandom_range(0, 63) == 0));
        end

        // Saturation of wr_count
        step('0, '0, 1'b0, '0, 1'b1);
        iter = 0;
        while (m_cnt != 65534 && iter < 70000) begin
            step(4'b1111, {$urandom}, 1'b0, '0, 1'b0);
            iter++;
        end
        check("sat_fffe", 32'(wr_count), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) step(4'b1111, {$urandom}, 1'b0, '0, 1'b0);
        check("sat_ffff", 32'(wr_count), 32'h0000FFFF);
        step(4'b1111, {$urandom}, 1'b0, '0, 1'b0);
        check("sat_hold", 32'(wr_count), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
